// File: rtl/vec_regfile.sv
// vec_regfile: NUM_REGS x (LANES*LANE_W) vector register file with per-lane write mask and busy scoreboard.
// Optional macro VREGFILE_BYPASS_EN adds a same-cycle write-through path on both read ports.
module vec_regfile #(
  parameter int NUM_REGS = 8,
  parameter int LANES    = 4,
  parameter int LANE_W   = 32,
  localparam int AW = $clog2(NUM_REGS),
  localparam int VW = LANES * LANE_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic [AW-1:0]       wr_addr,
  input  logic [LANES-1:0]    wr_mask,
  input  logic [VW-1:0]       wr_data,
  input  logic [AW-1:0]       rd_addr1,
  input  logic [AW-1:0]       rd_addr2,
  output logic [VW-1:0]       reg1_data,
  output logic [VW-1:0]       reg2_data,
  output logic                reg1_busy,
  output logic                reg2_busy,
  input  logic                rsv_en,
  input  logic [AW-1:0]       rsv_addr,
  output logic [NUM_REGS-1:0] busy_vec
);

  logic [VW-1:0]       rf_r [NUM_REGS];
  logic [NUM_REGS-1:0] busy_r;
  logic [NUM_REGS-1:0] busy_next_s;
  logic [VW-1:0]       wr_bits_s;

  function automatic logic [VW-1:0] lane_expand(input logic [LANES-1:0] mask);
    logic [VW-1:0] bits;
    bits = '0;
    for (int i = 0; i < LANES; i++) begin
      bits[i*LANE_W +: LANE_W] = {LANE_W{mask[i]}};
    end
    return bits;
  endfunction

  function automatic logic [VW-1:0] lane_merge(input logic [VW-1:0] old_v,
                                               input logic [VW-1:0] new_v,
                                               input logic [VW-1:0] bits);
    return (old_v & ~bits) | (new_v & bits);
  endfunction

  // Per-bit lane enable derived from the lane mask
  always_comb begin
    wr_bits_s = lane_expand(wr_mask);
  end

  // Scoreboard next state: a write releases, a reservation applied afterwards wins
  always_comb begin
    busy_next_s = busy_r;
    busy_next_s[wr_addr]  = busy_r[wr_addr] & ~we;
    busy_next_s[rsv_addr] = busy_next_s[rsv_addr] | rsv_en;
  end

  // Storage and scoreboard update
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        rf_r[r] <= '0;
      end
      busy_r <= '0;
    end else begin
      if (we) begin
        rf_r[wr_addr] <= lane_merge(rf_r[wr_addr], wr_data, wr_bits_s);
      end
      busy_r <= busy_next_s;
    end
  end

  // Combinational read ports
  always_comb begin
    reg1_data = rf_r[rd_addr1];
    reg2_data = rf_r[rd_addr2];
    reg1_busy = busy_r[rd_addr1];
    reg2_busy = busy_r[rd_addr2];
`ifdef VREGFILE_BYPASS_EN
    if (!rst && we && (rd_addr1 == wr_addr)) begin
      reg1_data = lane_merge(rf_r[rd_addr1], wr_data, wr_bits_s);
      reg1_busy = rsv_en && (rsv_addr == rd_addr1);
    end else if (!rst && rsv_en && (rsv_addr == rd_addr1)) begin
      reg1_busy = 1'b1;
    end else begin
      reg1_busy = busy_r[rd_addr1];
    end
    if (!rst && we && (rd_addr2 == wr_addr)) begin
      reg2_data = lane_merge(rf_r[rd_addr2], wr_data, wr_bits_s);
      reg2_busy = rsv_en && (rsv_addr == rd_addr2);
    end else if (!rst && rsv_en && (rsv_addr == rd_addr2)) begin
      reg2_busy = 1'b1;
    end else begin
      reg2_busy = busy_r[rd_addr2];
    end
`endif
  end

  assign busy_vec = busy_r;

endmodule

// File: tb/tb_vec_regfile.sv
// Scoreboard bench for vec_regfile: directed sequences plus random traffic against a lane-array model.
module tb_vec_regfile;
  localparam int NR = 8;
  localparam int LN = 4;
  localparam int LW = 32;
  localparam int AW = 3;
  localparam int VW = LN * LW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, we, rsv_en;
  logic [AW-1:0] wr_addr, rd_addr1, rd_addr2, rsv_addr;
  logic [LN-1:0] wr_mask;
  logic [VW-1:0] wr_data, reg1_data, reg2_data;
  logic          reg1_busy, reg2_busy;
  logic [NR-1:0] busy_vec;

  vec_regfile #(.NUM_REGS(NR), .LANES(LN), .LANE_W(LW)) dut (
    .clk(clk), .rst(rst), .we(we), .wr_addr(wr_addr), .wr_mask(wr_mask),
    .wr_data(wr_data), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .reg1_data(reg1_data), .reg2_data(reg2_data),
    .reg1_busy(reg1_busy), .reg2_busy(reg2_busy),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy_vec(busy_vec)
  );

  typedef struct {
    int            id;
    logic [VW-1:0] d1;
    logic [VW-1:0] d2;
    logic          b1;
    logic          b2;
    logic [NR-1:0] bv;
  } exp_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   issued      = 0;

  // Reference model: each register is an array of lanes, busy is one flag per register
  logic [LW-1:0] m_rf [NR][LN];
  bit            m_busy [NR];

  function automatic logic [VW-1:0] m_read(input int a);
    logic [VW-1:0] v;
    for (int i = 0; i < LN; i++) begin
      v[i*LW +: LW] = m_rf[a][i];
`ifdef VREGFILE_BYPASS_EN
      if (!rst && we && a == int'(wr_addr) && wr_mask[i]) v[i*LW +: LW] = wr_data[i*LW +: LW];
`endif
    end
    return v;
  endfunction

  function automatic logic m_busy_rd(input int a);
    logic b;
    b = m_busy[a];
`ifdef VREGFILE_BYPASS_EN
    if (!rst && we && a == int'(wr_addr)) b = rsv_en && (a == int'(rsv_addr));
    else if (!rst && rsv_en && a == int'(rsv_addr)) b = 1'b1;
`endif
    return b;
  endfunction

  task automatic cyc(input logic r, input logic w, input int wa, input logic [LN-1:0] wm,
                     input logic [VW-1:0] wd, input int a1, input int a2,
                     input logic rv, input int rva);
    exp_t e;
    logic [AW-1:0] t;
    rst = r; we = w; wr_mask = wm; wr_data = wd; rsv_en = rv;
    t = wa[AW-1:0];  wr_addr  = t;
    t = a1[AW-1:0];  rd_addr1 = t;
    t = a2[AW-1:0];  rd_addr2 = t;
    t = rva[AW-1:0]; rsv_addr = t;
    e.id = issued;
    e.d1 = m_read(a1);
    e.d2 = m_read(a2);
    e.b1 = m_busy_rd(a1);
    e.b2 = m_busy_rd(a2);
    for (int k = 0; k < NR; k++) e.bv[k] = m_busy[k];
    exp_q.push_back(e);
    issued++;
    @(posedge clk);
    if (r) begin
      for (int k = 0; k < NR; k++) begin
        m_busy[k] = 1'b0;
        for (int i = 0; i < LN; i++) m_rf[k][i] = '0;
      end
    end else begin
      if (w) begin
        for (int i = 0; i < LN; i++) if (wm[i]) m_rf[wa][i] = wd[i*LW +: LW];
        m_busy[wa] = 1'b0;
      end
      if (rv) m_busy[rva] = 1'b1;
    end
    #1;
  endtask

  // Monitor: pops one expectation per presented cycle and compares every output
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      vectors++;
      if (reg1_data !== e.d1) begin
        miscompares++;
        $display("FAIL v%0d reg1_data got %h exp %h", e.id, reg1_data, e.d1);
      end
      if (reg2_data !== e.d2) begin
        miscompares++;
        $display("FAIL v%0d reg2_data got %h exp %h", e.id, reg2_data, e.d2);
      end
      if (reg1_busy !== e.b1) begin
        miscompares++;
        $display("FAIL v%0d reg1_busy got %b exp %b", e.id, reg1_busy, e.b1);
      end
      if (reg2_busy !== e.b2) begin
        miscompares++;
        $display("FAIL v%0d reg2_busy got %b exp %b", e.id, reg2_busy, e.b2);
      end
      if (busy_vec !== e.bv) begin
        miscompares++;
        $display("FAIL v%0d busy_vec got %b exp %b", e.id, busy_vec, e.bv);
      end
    end
  end

  initial begin
    rst = 1'b1; we = 1'b0; rsv_en = 1'b0; wr_mask = '0; wr_data = '0;
    wr_addr = '0; rd_addr1 = '0; rd_addr2 = '0; rsv_addr = '0;
    for (int k = 0; k < NR; k++) begin
      m_busy[k] = 1'b0;
      for (int i = 0; i < LN; i++) m_rf[k][i] = '0;
    end
    @(posedge clk);
    #1;
    // Reset clear after preload and reservation
    for (int r = 0; r < NR; r++) cyc(1'b0, 1'b1, r, 4'hF, {4{32'hA5A5A5A5}}, r, (r + 1) % NR, 1'b0, 0);
    cyc(1'b0, 1'b0, 0, 4'h0, 128'h0, 3, 4, 1'b1, 3);
    cyc(1'b0, 1'b0, 0, 4'h0, 128'h0, 3, 7, 1'b0, 0);
    cyc(1'b1, 1'b1, 3, 4'hF, {4{32'h0BAD0BAD}}, 3, 1, 1'b1, 3);
    cyc(1'b0, 1'b0, 0, 4'h0, 128'h0, 3, 0, 1'b0, 0);
    // Masked write
    cyc(1'b0, 1'b1, 2, 4'hF, {32'h44, 32'h33, 32'h22, 32'h11}, 0, 1, 1'b0, 0);
    cyc(1'b0, 1'b1, 2, 4'b0101, {32'hDD, 32'hCC, 32'hBB, 32'hAA}, 2, 2, 1'b0, 0);
    cyc(1'b0, 1'b0, 0, 4'h0, 128'h0, 2, 3, 1'b0, 0);
    // Scoreboard reserve then release with empty mask
    cyc(1'b0, 1'b0, 0, 4'h0, 128'h0, 5, 4, 1'b1, 5);
    cyc(1'b0, 1'b0, 0, 4'h0, 128'h0, 5, 4, 1'b0, 0);
    cyc(1'b0, 1'b0, 0, 4'h0, 128'h0, 5, 4, 1'b0, 0);
    cyc(1'b0, 1'b1, 5, 4'h0, {4{32'hFFFFFFFF}}, 5, 4, 1'b0, 0);
    cyc(1'b0, 1'b0, 0, 4'h0, 128'h0, 5, 5, 1'b0, 0);
    // Same-cycle reserve and write
    cyc(1'b0, 1'b1, 6, 4'hF, {32'h66, 32'h77, 32'h88, 32'h99}, 6, 6, 1'b1, 6);
    cyc(1'b0, 1'b0, 0, 4'h0, 128'h0, 6, 6, 1'b0, 0);
    // Last index and index 0 on both ports
    cyc(1'b0, 1'b1, 7, 4'hF, {4{32'h000000FF}}, 7, 0, 1'b0, 0);
    cyc(1'b0, 1'b1, 0, 4'hF, {4{32'h00000001}}, 7, 0, 1'b0, 0);
    cyc(1'b0, 1'b0, 0, 4'h0, 128'h0, 7, 0, 1'b0, 0);
    // Write-through candidate on r1
    cyc(1'b0, 1'b1, 1, 4'b0011, {4{32'h12345678}}, 1, 1, 1'b0, 0);
    cyc(1'b0, 1'b0, 0, 4'h0, 128'h0, 1, 2, 1'b0, 0);
    // Random traffic
    for (int n = 0; n < 600; n++) begin
      cyc(($urandom_range(0, 63) == 0), ($urandom_range(0, 1) == 1), $urandom_range(0, NR - 1),
          4'($urandom_range(0, 15)), {$urandom(), $urandom(), $urandom(), $urandom()},
          $urandom_range(0, NR - 1), $urandom_range(0, NR - 1),
          ($urandom_range(0, 2) == 0), $urandom_range(0, NR - 1));
    end
    rst = 1'b0; we = 1'b0; rsv_en = 1'b0;
    repeat (2) @(negedge clk);
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain pending got %0d exp 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
